// File: rtl/mips_fetch_sequencer_if.sv
// Bus between the fetch sequencer and its neighbours: memory read
// channel and decoder flags in, state/instruction/debug counters out.
interface mips_fetch_sequencer_if #(
   parameter int unsigned CNT_W = 32
);
   logic             waitrequest;
   logic [31:0]      readdata;
   logic             extra;
   logic             halt;
   logic [1:0]       state;
   logic [31:0]      instr;
   logic             active;
   logic [CNT_W-1:0] retired;
   logic [CNT_W-1:0] stall_cycles;

   // Sequencer side
   modport master (
      input  waitrequest, readdata, extra, halt,
      output state, instr, active, retired, stall_cycles
   );

   // Memory / decoder side
   modport slave (
      output waitrequest, readdata, extra, halt,
      input  state, instr, active, retired, stall_cycles
   );
endinterface

// File: rtl/mips_fetch_sequencer.sv
// Multicycle MIPS fetch sequencer: owns the FETCH/EXEC1/EXEC2/HALT state
// register, captures the fetched word into the instruction register and
// keeps saturating retired-instruction and stall-cycle counters.
module mips_fetch_sequencer #(
   parameter int unsigned SWAP_BYTES = 1,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   mips_fetch_sequencer_if.master bus
);

   // Encoding is consumed directly by the decoder
   typedef enum logic [1:0] {
      FETCH = 2'b00,
      EXEC1 = 2'b01,
      EXEC2 = 2'b10,
      HALT  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      instr_q, instr_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [31:0]      fetch_word;
   logic [CNT_W-1:0] retired_inc, stall_inc;

   // Little-endian bus word to big-endian instruction word when enabled
   always_comb begin
      fetch_word = bus.readdata;
      if (SWAP_BYTES != 0) begin
         fetch_word = {bus.readdata[7:0], bus.readdata[15:8],
                       bus.readdata[23:16], bus.readdata[31:24]};
      end
   end

   // Saturating increment candidates for both counters
   always_comb begin
      retired_inc = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);
      stall_inc   = (stall_q == '1)   ? stall_q   : stall_q + CNT_W'(1);
   end

   // State, instruction and counter registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= FETCH;
         instr_q   <= '0;
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
         stall_q   <= stall_d;
      end
   end

   // Next-state decision; halt outranks waitrequest in FETCH
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      stall_d   = stall_q;
      case (state_q)
         FETCH: begin
            if (bus.halt) begin
               state_d = HALT;
            end else if (bus.waitrequest) begin
               stall_d = stall_inc;
            end else begin
               state_d = EXEC1;
               instr_d = fetch_word;
            end
         end
         EXEC1: begin
            if (bus.waitrequest) begin
               stall_d = stall_inc;
            end else if (bus.extra) begin
               state_d = EXEC2;
            end else begin
               state_d   = FETCH;
               retired_d = retired_inc;
            end
         end
         EXEC2: begin
            state_d   = FETCH;
            retired_d = retired_inc;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   assign bus.state        = state_q;
   assign bus.instr        = instr_q;
   assign bus.active       = (state_q != HALT);
   assign bus.retired      = retired_q;
   assign bus.stall_cycles = stall_q;

endmodule
